// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; every line level lasts one baud_pulse interval.
// Frames are start bit, DATA_W data bits LSB first, then STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk_fast,
    input  logic                          rst_n,
    input  logic                          baud_pulse,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic               tx_q, tx_d;
    logic               push, pop, fifo_empty, last_stop;

    // Fullness and emptiness use the current count, so a same-cycle pop never frees a slot
    // for a write and a same-cycle write never feeds a pop.
    assign din_ready  = (count_q != CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = din_valid && din_ready && rst_n;
    assign last_stop  = (int'(stop_cnt_q) >= STOP_BITS - 1);
    assign pop        = baud_pulse && !fifo_empty &&
                        ((state_q == IDLE) || ((state_q == STOP) && last_stop));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        if (baud_pulse) begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
                START: begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (!last_stop) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                        tx_d       = 1'b1;
                    end else if (pop) begin
                        // Back-to-back frame: next start bit follows the last stop bit directly.
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset: only slots below the occupancy count are ever read.
    always_ff @(posedge clk_fast) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning data bits per frame.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning the number of entries in the input FIFO; the value is a power of 2 and at least 2.
REQ-003 SHALL provide parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 and 2.
REQ-004 SHALL have port clk_fast, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port baud_pulse, input, 1 bit: one-clk_fast-cycle strobe per bit period, sourced by the upstream pulse generator in the clk_fast domain.
REQ-007 SHALL have port din, input, DATA_W bits: the byte to transmit.
REQ-008 SHALL have port din_valid, input, 1 bit: din holds a valid byte.
REQ-009 SHALL have port din_ready, output, 1 bit: the FIFO can accept a write.
REQ-010 SHALL have port tx, output, 1 bit: registered serial line, idle-high.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-013 SHALL drive din_ready = (fifo_count != FIFO_DEPTH) combinationally.
REQ-014 SHALL write din into the FIFO on any clk_fast edge where din_valid && din_ready; din_valid while full is ignored and leaves no side effect.
REQ-015 SHALL block a write when the FIFO is full, even if a pop occurs in the same cycle.
REQ-016 SHALL perform no pop when the FIFO is empty, even if a write occurs in the same cycle; the written word is popped at a later pulse.
REQ-017 SHALL update fifo_count by +1 on write only, -1 on pop only, and 0 on both or neither; read and write pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL implement a state machine with states IDLE, START, DATA and STOP; state, shift register, counters and tx change only on cycles where baud_pulse=1, apart from FIFO writes.
REQ-019 SHALL, in IDLE with baud_pulse=1 and FIFO non-empty: pop the head into the shift register, set tx<=0 and move to START; with the FIFO empty, remain in IDLE with tx=1.
REQ-020 SHALL, in START with baud_pulse=1: set tx<=shift[0], shift right, set bit_cnt<=0 and move to DATA.
REQ-021 SHALL, in DATA with baud_pulse=1: if bit_cnt==DATA_W-1, set tx<=1, clear stop_cnt and move to STOP; otherwise set tx<=shift[0], shift right and increment bit_cnt.
REQ-022 SHALL transmit bits LSB first.
REQ-023 SHALL, in STOP with baud_pulse=1: if stop_cnt<STOP_BITS-1, increment stop_cnt and hold tx=1; otherwise, if the FIFO is non-empty, pop, set tx<=0 and go to START (back-to-back, no idle bit); else go to IDLE with tx=1.
REQ-024 SHALL make every line level last exactly one baud_pulse interval; a frame is 1 + DATA_W + STOP_BITS intervals.
REQ-025 SHALL drive busy = (state != IDLE).
REQ-026 SHALL leave all state unchanged when baud_pulse is held low indefinitely; tx holds its value.
REQ-027 SHALL be tolerant of baud_pulse high for multiple consecutive cycles; each high cycle counts as one bit period.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state=IDLE, tx=1, busy=0, fifo_count=0, pointers=0, bit_cnt=0, stop_cnt=0 and shift register=0.
REQ-029 SHALL abort any frame in progress on reset mid-frame and discard FIFO contents; after release, din_ready=1.
REQ-030 SHALL accept no writes while rst_n=0.

Verification
REQ-031 SHALL cover: push 0xA5, baud_pulse every 4 clocks -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; busy high for 10 pulse intervals, then 0.
REQ-032 SHALL cover: push 5 words with baud_pulse low -> fifo_count=4 and din_ready=0 after the 4th write; the 5th is dropped; words 1-4 are later sent in order.
REQ-033 SHALL cover: queue 0x00 then 0xFF -> the first stop bit is immediately followed by the second start bit; busy stays 1 through 20 intervals.
REQ-034 SHALL cover: rst_n low during DATA bit 3 -> tx=1, busy=0 and fifo_count=0 in the same cycle without waiting for a clock; a subsequent push of 0x3C transmits correctly.
REQ-035 SHALL cover: baud_pulse with the FIFO empty, plus a simultaneous push and pulse in IDLE -> tx stays 1 that cycle, and start is asserted on the next pulse.
REQ-036 SHALL cover: STOP_BITS=2 with 0x55 -> a frame of 11 intervals ending with two 1s.
